// File: rtl/ws2811_frame_controller.sv
// WS2811 frame sequencer: fetches PIXEL_COUNT 24-bit words and serialises them as NRZ pulses, then latches.
// Optional continuous-repeat mode is enabled by defining WS2811_REPEAT_EN.
module ws2811_frame_controller #(
   parameter int unsigned T0H_CYCLES   = 13,
   parameter int unsigned T1H_CYCLES   = 30,
   parameter int unsigned BIT_CYCLES   = 63,
   parameter int unsigned RESET_CYCLES = 2750,
   parameter int unsigned PIXEL_COUNT  = 8,
   localparam int unsigned AW = (PIXEL_COUNT > 1) ? $clog2(PIXEL_COUNT) : 1
) (
   input  logic          clkIN,
   input  logic          nResetIN,
   input  logic          startIN,
   output logic          pixelReqOUT,
   output logic [AW-1:0] pixelAddrOUT,
   input  logic [23:0]   pixelDataIN,
   input  logic          pixelValidIN,
   output logic          doutOUT,
   output logic          busyOUT,
   output logic          doneOUT
);

   localparam int unsigned CW = $clog2(BIT_CYCLES);
   localparam int unsigned LW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(PIXEL_COUNT - 1);

   if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES &&
         RESET_CYCLES >= 1 && PIXEL_COUNT >= 1)) begin : g_param_check
      $error("ws2811_frame_controller: illegal timing parameters");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SEND  = 2'd2,
      ST_LATCH = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [23:0]   sreg_q, sreg_d;
   logic [4:0]    bit_idx_q, bit_idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [LW-1:0] latch_q, latch_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          req_q, req_d;
   logic          dout_q, dout_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          bit_end_s, last_bit_s, last_pix_s, latch_end_s;
   logic [CW-1:0] cnt_inc_s, th_s;

   assign bit_end_s   = (cnt_q == CW'(BIT_CYCLES - 1));
   assign last_bit_s  = (bit_idx_q == 5'd23);
   assign last_pix_s  = (addr_q == LAST_ADDR);
   assign latch_end_s = (latch_q == LW'(RESET_CYCLES - 1));
   assign cnt_inc_s   = cnt_q + CW'(1);
   assign th_s        = sreg_q[23] ? CW'(T1H_CYCLES) : CW'(T0H_CYCLES);

   always_ff @(posedge clkIN or negedge nResetIN) begin
      if (!nResetIN) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clkIN or negedge nResetIN) begin
      if (!nResetIN) begin
         sreg_q    <= 24'd0;
         bit_idx_q <= 5'd0;
         cnt_q     <= '0;
         latch_q   <= '0;
         addr_q    <= '0;
         req_q     <= 1'b0;
         dout_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         sreg_q    <= sreg_d;
         bit_idx_q <= bit_idx_d;
         cnt_q     <= cnt_d;
         latch_q   <= latch_d;
         addr_q    <= addr_d;
         req_q     <= req_d;
         dout_q    <= dout_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (startIN) state_d = ST_FETCH;
            else         state_d = ST_IDLE;
         end
         ST_FETCH: begin
            if (pixelValidIN) state_d = ST_SEND;
            else              state_d = ST_FETCH;
         end
         ST_SEND: begin
            if (bit_end_s && last_bit_s) state_d = last_pix_s ? ST_LATCH : ST_FETCH;
            else                         state_d = ST_SEND;
         end
         ST_LATCH: begin
            if (latch_end_s) begin
`ifdef WS2811_REPEAT_EN
               state_d = startIN ? ST_FETCH : ST_IDLE;
`else
               state_d = ST_IDLE;
`endif
            end else begin
               state_d = ST_LATCH;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      sreg_d    = sreg_q;
      bit_idx_d = bit_idx_q;
      cnt_d     = cnt_q;
      latch_d   = latch_q;
      addr_d    = addr_q;
      req_d     = req_q;
      dout_d    = dout_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (startIN) begin
               req_d  = 1'b1;
               addr_d = '0;
               busy_d = 1'b1;
            end else begin
               dout_d = 1'b0;
            end
         end
         ST_FETCH: begin
            if (pixelValidIN) begin
               sreg_d    = pixelDataIN;
               req_d     = 1'b0;
               bit_idx_d = 5'd0;
               cnt_d     = '0;
               dout_d    = 1'b1;
            end else begin
               dout_d = 1'b0;
            end
         end
         ST_SEND: begin
            // dout for the next cycle is decided by the count that cycle will hold
            if (bit_end_s) begin
               cnt_d = '0;
               if (!last_bit_s) begin
                  sreg_d    = sreg_q << 1;
                  bit_idx_d = bit_idx_q + 5'd1;
                  dout_d    = 1'b1;
               end else if (!last_pix_s) begin
                  addr_d = addr_q + AW'(1);
                  req_d  = 1'b1;
                  dout_d = 1'b0;
               end else begin
                  dout_d  = 1'b0;
                  latch_d = '0;
               end
            end else begin
               cnt_d  = cnt_inc_s;
               dout_d = (cnt_inc_s < th_s);
            end
         end
         ST_LATCH: begin
            dout_d = 1'b0;
            if (latch_end_s) begin
               done_d  = 1'b1;
               latch_d = '0;
`ifdef WS2811_REPEAT_EN
               if (startIN) begin
                  addr_d = '0;
                  req_d  = 1'b1;
               end else begin
                  busy_d = 1'b0;
               end
`else
               busy_d = 1'b0;
`endif
            end else begin
               latch_d = latch_q + LW'(1);
            end
         end
         default: begin
            dout_d = 1'b0;
         end
      endcase
   end

   assign pixelReqOUT  = req_q;
   assign pixelAddrOUT = addr_q;
   assign doutOUT      = dout_q;
   assign busyOUT      = busy_q;
   assign doneOUT      = done_q;

endmodule
